// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared defaults and ratio type for the multi-channel clock divider
package clk_div_pkg;

    localparam int CNT_W_DEF = 8;

    typedef logic [CNT_W_DEF-1:0] ratio_t;

    localparam ratio_t RST_RATIO_DEF = '0;

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, active/shadow ratio, pending load, tick and ack
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [CNT_W-1:0] ratio_in,
    input  logic             load,
    output logic             div_out,
    output logic             tick,
    output logic             load_ack
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             div_q, div_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             wrap;

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        div_d    = div_q;
        tick_d   = 1'b0;
        ack_d    = 1'b0;
        wrap     = (cnt_q == active_q);

        // Loads are always captured, even while frozen or held in clear.
        if (load) begin
            shadow_d = ratio_in;
            pend_d   = 1'b1;
        end

        if (sync_clr) begin
            cnt_d = '0;
            div_d = 1'b0;
        end else if (en) begin
            if (wrap) begin
                cnt_d  = '0;
                div_d  = ~div_q;
                tick_d = ~div_q;
                // New ratio only takes effect at a half-period boundary.
                if (pend_q) begin
                    active_d = load ? ratio_in : shadow_q;
                    pend_d   = 1'b0;
                    ack_d    = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            active_q <= RST_VAL;
            shadow_q <= RST_VAL;
            pend_q   <= 1'b0;
            div_q    <= 1'b0;
            tick_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            div_q    <= div_d;
            tick_q   <= tick_d;
            ack_q    <= ack_d;
        end
    end

    assign div_out  = div_q;
    assign tick     = tick_q;
    assign load_ack = ack_q;

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - NCH-channel clock divider with registered masked AND (CLK_DIV_AND_EN)
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int RST_RATIO = int'(RST_RATIO_DEF)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               sync_clr,
    input  logic [NCH*CNT_W-1:0] div_ratio,
    input  logic [NCH-1:0]     load,
    input  logic [NCH-1:0]     and_mask,
    output logic [NCH-1:0]     div_out,
    output logic [NCH-1:0]     tick,
    output logic [NCH-1:0]     load_ack,
    output logic               and_out
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clk_div_chan #(
            .CNT_W   (CNT_W),
            .RST_VAL (CNT_W'(RST_RATIO))
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .en       (en),
            .sync_clr (sync_clr),
            .ratio_in (div_ratio[i*CNT_W +: CNT_W]),
            .load     (load[i]),
            .div_out  (div_out[i]),
            .tick     (tick[i]),
            .load_ack (load_ack[i])
        );
    end

`ifdef CLK_DIV_AND_EN
    logic and_q, and_d;

    // Unmasked channels read as 1 so an empty mask yields 1.
    always_comb begin
        and_d = &(div_out | ~and_mask);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            and_q <= 1'b0;
        end else begin
            and_q <= and_d;
        end
    end

    assign and_out = and_q;
`else
    assign and_out = 1'b0 & (^and_mask);
`endif

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels.
REQ-002 Parameter CNT_W, default 8: width of each channel's ratio and counter.
REQ-003 Parameter RST_RATIO, default 0: active ratio loaded into every channel at reset.
REQ-004 clk  in  1  single clock; all logic SHALL be clocked on its rising edge, with no derived or ripple clocks.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  global count enable.
REQ-007 sync_clr  in  1  synchronous phase-align clear.
REQ-008 div_ratio  in  NCH*CNT_W  per-channel requested ratio R; channel i uses slice [i*CNT_W +: CNT_W].
REQ-009 load  in  NCH  per-channel request to adopt its div_ratio slice.
REQ-010 and_mask  in  NCH  selects the channels ANDed onto and_out.
REQ-011 div_out  out  NCH  registered divided outputs.
REQ-012 tick  out  NCH  one-cycle pulse on each div_out rising transition.
REQ-013 load_ack  out  NCH  one-cycle pulse when a new ratio becomes active.
REQ-014 and_out  out  1  registered AND of masked div_out bits.

Function
REQ-015 Each channel SHALL hold a counter, an active ratio, a shadow ratio and a pending flag.
REQ-016 With en=1, counter SHALL increment each cycle; when counter == active ratio it SHALL wrap to 0 and div_out SHALL toggle, giving period 2*(R+1) cycles and 50% duty (R=0 gives divide-by-2).
REQ-017 load[i]=1 SHALL capture the slice into shadow and set pending; a repeated load while pending SHALL overwrite the shadow (last wins).
REQ-018 At a wrap with pending set, active SHALL take the shadow (or the live slice if load is high that same cycle), pending SHALL clear, and load_ack SHALL pulse in the next cycle; mid-period ratio changes SHALL never shorten a half-period.
REQ-019 tick[i] SHALL be high exactly in the cycle div_out[i] first reads 1.
REQ-020 With en=0, counters, div_out and pending-application SHALL hold; tick and load_ack SHALL be 0; loads SHALL still be captured.
REQ-021 sync_clr SHALL override en: all counters and div_out go to 0 next cycle, tick 0, with shadow/pending retained; the next application happens at the first wrap after release.
REQ-022 and_out SHALL register &(div_out | ~and_mask); and_mask = 0 SHALL yield and_out = 1.

Reset
REQ-023 reset SHALL asynchronously force counters, div_out, tick, load_ack, pending and and_out to 0.
REQ-024 reset SHALL set active and shadow ratios to RST_RATIO.
REQ-025 reset asserted mid-period SHALL discard any pending load.

Configuration
REQ-026 Macro CLK_DIV_AND_EN defined: the and_mask/and_out logic of REQ-022 SHALL be present.
REQ-027 Macro CLK_DIV_AND_EN undefined: and_out SHALL be constant 0, and and_mask SHALL be ignored.

Structure
REQ-028 Package clk_div_pkg SHALL hold the CNT_W default, the ratio typedef and the RST_RATIO default.
REQ-029 One sub-module, clk_div_chan, SHALL implement a single channel and SHALL be instantiated NCH times by a generate loop; the AND combine SHALL stay in the top level.

Verification
REQ-030 Reset release, all R=0, en=1: every div_out SHALL toggle each cycle, and tick SHALL be high every other cycle.
REQ-031 ch1 at R=1, load R=3 when counter=0: the current half-period SHALL stay 2 cycles, load_ack[1] SHALL pulse once, and the subsequent period SHALL be 8 cycles.
REQ-032 en=0 for 5 cycles mid-period: div_out SHALL be frozen and tick 0; on resume, the remaining half-period length SHALL be unchanged.
REQ-033 ch0 R=0, ch1 R=2, sync_clr pulse: both outputs SHALL be 0 next cycle, and rising edges SHALL coincide every 6 cycles thereafter.
REQ-034 and_mask=4'b0011, R0=0, R1=1 (CLK_DIV_AND_EN): and_out SHALL be high 1 cycle in every 4.
REQ-035 Asynchronous reset during a pending load: outputs SHALL be 0 before the next clk edge, and the period SHALL then follow RST_RATIO with no load_ack.
